sram_mem_controller: RTL and testbench

- MEM-stage data-memory controller; replaces the single-cycle data memory.
- Consumes the EXE-register outputs: ALU result (address), forwarded Rm value (store data), and the MEM read/write enables.
- Performs each 32-bit access as two 16-bit accesses to an external asynchronous SRAM, with programmable wait states.
- Drives ready low while busy; the hazard/freeze logic uses this to stall every pipeline register.

---
 rtl/sram_mem_controller_pkg.sv | 39 +++
 rtl/sram_mem_controller_wait_counter.sv | 37 +++
 rtl/sram_mem_controller.sv | 139 +++++++++++++
 tb/tb_sram_mem_controller.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sram_mem_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_mem_controller_pkg
// Description : Shared state encoding, SRAM widths and address defaults for
//               the MEM-stage SRAM data-memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_mem_controller_pkg;

    localparam int unsigned BASE_ADDR_DEFAULT   = 32'd1024;
    localparam int unsigned WAIT_CYCLES_DEFAULT = 4;
    localparam int unsigned SRAM_ADDR_W_DEFAULT = 18;
    localparam int unsigned SRAM_DATA_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_LO = 3'd1,
        ST_RD_HI = 3'd2,
        ST_WR_LO = 3'd3,
        ST_WR_HI = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // True for the four timed half-access states.
    function automatic logic is_access(input state_e s);
        return (s == ST_RD_LO) || (s == ST_RD_HI) ||
               (s == ST_WR_LO) || (s == ST_WR_HI);
    endfunction

    function automatic logic is_write(input state_e s);
        return (s == ST_WR_LO) || (s == ST_WR_HI);
    endfunction

    function automatic logic is_read(input state_e s);
        return (s == ST_RD_LO) || (s == ST_RD_HI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_mem_controller_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : sram_wait_counter
// Description : Wait-state counter. Counts 0..COUNT-1 while enabled, clears
//               synchronously on clear_i, flags the final cycle on last_o.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_wait_counter #(
    parameter int unsigned COUNT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic last_o
);

    localparam int unsigned   CNT_W  = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(COUNT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Cycle counter within the current half-access; restarts at every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign last_o = (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/sram_mem_controller.sv
`default_nettype none
// ============================================================================
// Module      : sram_mem_controller
// Description : MEM-stage data-memory controller. Splits each 32-bit load or
//               store into two 16-bit accesses on an asynchronous SRAM with
//               programmable wait states; ready=0 freezes the pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_mem_controller
    import sram_mem_controller_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = BASE_ADDR_DEFAULT,
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
    parameter int unsigned SRAM_ADDR_W = SRAM_ADDR_W_DEFAULT,
    parameter int unsigned SRAM_DATA_W = SRAM_DATA_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [31:0]              address,
    input  logic [31:0]              write_data,
    output logic [31:0]              read_data,
    output logic                     ready,
    inout  wire  [SRAM_DATA_W-1:0]   SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0]   SRAM_ADDR,
    output logic                     SRAM_UB_N,
    output logic                     SRAM_LB_N,
    output logic                     SRAM_CE_N,
    output logic                     SRAM_OE_N,
    output logic                     SRAM_WE_N
);

    state_e                   state_q, state_d;
    logic [31:0]              read_data_q;
    logic [SRAM_DATA_W-1:0]   lo_half_q;
    logic                     we_n_q;
    logic                     oe_n_q;
    logic                     dq_oe_q;

    logic                     w_busy;
    logic                     w_last;
    logic                     w_clear;
    logic [31:0]              w_offset;
    logic [SRAM_ADDR_W-2:0]   w_word;
    logic [SRAM_DATA_W-1:0]   w_dq_out;
    logic                     w_unused_bits;

    // Byte address -> SRAM word; the wrap-around of the subtraction is intended.
    assign w_offset      = address - BASE_ADDR;
    assign w_word        = w_offset[SRAM_ADDR_W:2];
    assign w_unused_bits = ^{w_offset[31:SRAM_ADDR_W+1], w_offset[1:0]};

    assign w_busy  = is_access(state_q);
    assign w_clear = !w_busy || w_last;

    sram_wait_counter #(
        .COUNT   (WAIT_CYCLES)
    ) u_wait_counter (
        .clk     (clk),
        .rst     (rst),
        .clear_i (w_clear),
        .en_i    (w_busy),
        .last_o  (w_last)
    );

    // Next-state decode; a simultaneous read and write is taken as a write.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (wr_en)      state_d = ST_WR_LO;
                else if (rd_en) state_d = ST_RD_LO;
            end
            ST_RD_LO: if (w_last) state_d = ST_RD_HI;
            ST_RD_HI: if (w_last) state_d = ST_DONE;
            ST_WR_LO: if (w_last) state_d = ST_WR_HI;
            ST_WR_HI: if (w_last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register plus strobes registered from the next state, so WE_N/OE_N
    // are glitch-free and WE_N rises exactly on the write-state exit edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
        end else begin
            state_q <= state_d;
            we_n_q  <= !is_write(state_d);
            oe_n_q  <= !is_read(state_d);
            dq_oe_q <= is_write(state_d);
        end
    end

    // Read datapath: capture each half on the final wait cycle of its state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lo_half_q   <= '0;
            read_data_q <= '0;
        end else begin
            if (state_q == ST_RD_LO && w_last) begin
                lo_half_q <= SRAM_DQ;
            end
            if (state_q == ST_RD_HI && w_last) begin
                read_data_q <= {SRAM_DQ, lo_half_q};
            end
        end
    end

    // Half-word address follows the current state; parked at zero when idle.
    always_comb begin
        SRAM_ADDR = '0;
        unique case (state_q)
            ST_RD_LO, ST_WR_LO: SRAM_ADDR = {w_word, 1'b0};
            ST_RD_HI, ST_WR_HI: SRAM_ADDR = {w_word, 1'b1};
            default:            SRAM_ADDR = '0;
        endcase
    end

    assign w_dq_out  = (state_q == ST_WR_HI) ? write_data[31:16] : write_data[15:0];
    assign SRAM_DQ   = dq_oe_q ? w_dq_out : {SRAM_DATA_W{1'bz}};

    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_UB_N = ~rst;
    assign SRAM_LB_N = ~rst;
    assign SRAM_CE_N = ~rst;

    assign read_data = read_data_q;
    assign ready     = ((state_q == ST_IDLE) && !(wr_en || rd_en)) ||
                       (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_sram_mem_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_mem_controller
// Description : Self-checking bench: two controller instances (4 and 1 wait
//               states), each on a behavioural async SRAM; read results are
//               checked against a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_mem_controller;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        wr0 = 1'b0, rd0 = 1'b0, wr1 = 1'b0, rd1 = 1'b0;
    logic [31:0] a0 = '0, d0 = '0, a1 = '0, d1 = '0;
    logic [31:0] rdata0, rdata1;
    logic        rdy0, rdy1;
    wire  [15:0] dq0, dq1;
    logic [17:0] sa0, sa1;
    logic        ub0, lb0, ce0, oe0, we0;
    logic        ub1, lb1, ce1, oe1, we1;

    logic [15:0] mem0 [0:63];
    logic [15:0] mem1 [0:63];

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] sb[$];

    sram_mem_controller #(.WAIT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .wr_en(wr0), .rd_en(rd0), .address(a0),
        .write_data(d0), .read_data(rdata0), .ready(rdy0), .SRAM_DQ(dq0),
        .SRAM_ADDR(sa0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0), .SRAM_CE_N(ce0),
        .SRAM_OE_N(oe0), .SRAM_WE_N(we0)
    );

    sram_mem_controller #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(rd1), .address(a1),
        .write_data(d1), .read_data(rdata1), .ready(rdy1), .SRAM_DQ(dq1),
        .SRAM_ADDR(sa1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1), .SRAM_CE_N(ce1),
        .SRAM_OE_N(oe1), .SRAM_WE_N(we1)
    );

    // Behavioural SRAMs: drive the bus while output-enabled, store while write-enabled.
    assign dq0 = (!oe0 && we0 && !ce0) ? mem0[sa0[5:0]] : 16'bz;
    assign dq1 = (!oe1 && we1 && !ce1) ? mem1[sa1[5:0]] : 16'bz;

    always @(posedge clk) begin
        if (!we0 && !ce0) mem0[sa0[5:0]] <= dq0;
        if (!we1 && !ce1) mem1[sa1[5:0]] <= dq1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One access on instance sel: drive at a falling edge, count ready-low,
    // WE_N-low and OE_N-low cycles until ready rises, then check read data.
    task automatic run_access(input bit sel, input bit wr, input bit rd,
                              input logic [31:0] addr, input logic [31:0] data,
                              input bit hold, output int rlow, output int welow,
                              output int oelow);
        logic r, w, o;
        logic [31:0] exp;
        rlow = 0; welow = 0; oelow = 0;
        @(negedge clk);
        if (sel) begin wr1 = wr; rd1 = rd; a1 = addr; d1 = data; end
        else     begin wr0 = wr; rd0 = rd; a0 = addr; d0 = data; end
        #1;
        r = sel ? rdy1 : rdy0; w = sel ? we1 : we0; o = sel ? oe1 : oe0;
        while (!r && rlow < 60) begin
            rlow++;
            if (!w) welow++;
            if (!o) oelow++;
            @(negedge clk);
            #1;
            r = sel ? rdy1 : rdy0; w = sel ? we1 : we0; o = sel ? oe1 : oe0;
        end
        if (!r) chk("ready_timeout", {31'b0, r}, 32'd1);
        if (rd && !wr && sb.size() > 0) begin
            exp = sb.pop_front();
            chk("read_data", sel ? rdata1 : rdata0, exp);
        end
        if (!hold) begin
            if (sel) begin wr1 = 1'b0; rd1 = 1'b0; end
            else     begin wr0 = 1'b0; rd0 = 1'b0; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int rl, wl, ol;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", {31'b0, rdy0}, 32'd1);
        chk("rst_read_data", rdata0, 32'h0);
        chk("rst_we_n", {31'b0, we0}, 32'd1);
        chk("rst_oe_n", {31'b0, oe0}, 32'd1);
        chk("rst_addr", {14'b0, sa0}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ce_n_active", {31'b0, ce0}, 32'd0);

        // Store 0xDEADBEEF to 1032 -> SRAM words 4/5
        run_access(1'b0, 1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 1'b0, rl, wl, ol);
        chk("st_ready_low", rl, 32'd9);
        chk("st_we_low", wl, 32'd8);
        chk("st_oe_low", ol, 32'd0);
        chk("st_mem4", {16'b0, mem0[4]}, 32'h0000BEEF);
        chk("st_mem5", {16'b0, mem0[5]}, 32'h0000DEAD);
        chk("st_rdata_hold", rdata0, 32'h0);

        // Load it back
        sb.push_back(32'hDEADBEEF);
        run_access(1'b0, 1'b0, 1'b1, 32'd1032, 32'h0, 1'b0, rl, wl, ol);
        chk("ld_ready_low", rl, 32'd9);
        chk("ld_oe_low", ol, 32'd8);
        chk("ld_we_low", wl, 32'd0);

        // Back-to-back loads with rd_en held through DONE
        run_access(1'b0, 1'b1, 1'b0, 32'd1028, 32'h11112222, 1'b0, rl, wl, ol);
        sb.push_back(32'h11112222);
        sb.push_back(32'h11112222);
        run_access(1'b0, 1'b0, 1'b1, 32'd1028, 32'h0, 1'b1, rl, wl, ol);
        chk("b2b1_ready_low", rl, 32'd9);
        chk("b2b1_oe_low", ol, 32'd8);
        run_access(1'b0, 1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, rl, wl, ol);
        chk("b2b2_ready_low", rl, 32'd9);
        chk("b2b2_oe_low", ol, 32'd8);

        // Simultaneous read+write is a write
        run_access(1'b0, 1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b0, rl, wl, ol);
        chk("sim_we_low", wl, 32'd8);
        chk("sim_oe_low", ol, 32'd0);
        chk("sim_mem0", {16'b0, mem0[0]}, 32'h00005678);
        chk("sim_mem1", {16'b0, mem0[1]}, 32'h00001234);
        chk("sim_rdata_hold", rdata0, 32'h11112222);

        // Single-wait-state instance
        run_access(1'b1, 1'b1, 1'b0, 32'd1024, 32'hCAFEF00D, 1'b0, rl, wl, ol);
        chk("w1_st_ready_low", rl, 32'd3);
        chk("w1_st_we_low", wl, 32'd2);
        chk("w1_mem0", {16'b0, mem1[0]}, 32'h0000F00D);
        chk("w1_mem1", {16'b0, mem1[1]}, 32'h0000CAFE);
        sb.push_back(32'hCAFEF00D);
        run_access(1'b1, 1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, rl, wl, ol);
        chk("w1_ld_ready_low", rl, 32'd3);
        chk("w1_ld_oe_low", ol, 32'd2);

        // Reset asserted in the middle of WR_LO
        @(negedge clk);
        wr0 = 1'b1; a0 = 32'd1040; d0 = 32'h5555AAAA;
        repeat (2) @(negedge clk);
        #1;
        chk("mid_in_write", {31'b0, we0}, 32'd0);
        rst = 1'b0;
        wr0 = 1'b0;
        #1;
        chk("mid_rst_we_n", {31'b0, we0}, 32'd1);
        chk("mid_rst_oe_n", {31'b0, oe0}, 32'd1);
        chk("mid_rst_ready", {31'b0, rdy0}, 32'd1);
        chk("mid_rst_rdata", rdata0, 32'h0);
        chk("mid_rst_addr", {14'b0, sa0}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_we_n", {31'b0, we0}, 32'd1);
        chk("post_rst_ready", {31'b0, rdy0}, 32'd1);
        chk("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
